// File: rtl/dx_issue_latch.sv
// Decode->execute pipeline register: operand select/forwarding, ALU control decode,
// hold/flush handling and a saturating bubble counter. Forwarding is enabled by DX_BYPASS_EN.
module dx_src_sel (
   input  logic [4:0]  addr,
   input  logic [31:0] rf_data,
   input  logic        xm_wr_en,
   input  logic [4:0]  xm_rd,
   input  logic [31:0] xm_value,
   input  logic        mw_wr_en,
   input  logic [4:0]  mw_rd,
   input  logic [31:0] mw_value,
   output logic [31:0] value,
   output logic        conflict
);
   logic zero_src, xm_hit, mw_hit;

   assign zero_src = (addr == 5'd0);
   assign xm_hit   = xm_wr_en && (xm_rd == addr) && !zero_src;
   assign mw_hit   = mw_wr_en && (mw_rd == addr) && !zero_src;
   assign conflict = xm_hit || mw_hit;

`ifdef DX_BYPASS_EN
   // XM is the younger producer, so it wins over MW
   always_comb begin
      value = rf_data;
      if (zero_src)    value = '0;
      else if (xm_hit) value = xm_value;
      else if (mw_hit) value = mw_value;
   end
`else
   logic unused_fwd;
   assign unused_fwd = ^{xm_value, mw_value};
   assign value      = zero_src ? '0 : rf_data;
`endif
endmodule

module dx_issue_latch #(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             d_valid,
   input  logic [31:0]      d_insn,
   input  logic [31:0]      d_pc,
   input  logic [4:0]       d_a_addr,
   input  logic [4:0]       d_b_addr,
   input  logic [31:0]      d_a_data,
   input  logic [31:0]      d_b_data,
   input  logic             xm_wr_en,
   input  logic [4:0]       xm_rd,
   input  logic [31:0]      xm_value,
   input  logic             mw_wr_en,
   input  logic [4:0]       mw_rd,
   input  logic [31:0]      mw_value,
   input  logic             hold,
   input  logic             flush,
   output logic             x_valid,
   output logic [31:0]      x_operandA,
   output logic [31:0]      x_operandB,
   output logic [4:0]       x_aluop,
   output logic [4:0]       x_shamt,
   output logic [4:0]       x_rd,
   output logic             x_wr_en,
   output logic [31:0]      x_pc,
   output logic [31:0]      x_insn,
   output logic             hazard,
   output logic [CNT_W-1:0] bubble_count
);
   localparam int NUM_SRC = 2;

   typedef struct packed {
      logic        valid;
      logic [31:0] op_a;
      logic [31:0] op_b;
      logic [4:0]  aluop;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        wr_en;
      logic [31:0] pc;
      logic [31:0] insn;
   } dx_t;

   logic [NUM_SRC-1:0][4:0]  src_addr;
   logic [NUM_SRC-1:0][31:0] src_rf;
   logic [NUM_SRC-1:0][31:0] src_val;
   logic [NUM_SRC-1:0]       src_hit;

   assign src_addr = {d_b_addr, d_a_addr};
   assign src_rf   = {d_b_data, d_a_data};

   // index 0 = operand A, index 1 = operand B
   generate
      for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
         dx_src_sel u_sel (
            .addr     (src_addr[s]),
            .rf_data  (src_rf[s]),
            .xm_wr_en (xm_wr_en),
            .xm_rd    (xm_rd),
            .xm_value (xm_value),
            .mw_wr_en (mw_wr_en),
            .mw_rd    (mw_rd),
            .mw_value (mw_value),
            .value    (src_val[s]),
            .conflict (src_hit[s])
         );
      end
   endgenerate

   logic [4:0]  op;
   logic [4:0]  dec_aluop, dec_shamt;
   logic        dec_wr, use_imm;
   logic [31:0] imm_ext;
   dx_t         nxt, cur;

   assign op      = d_insn[31:27];
   assign imm_ext = {{15{d_insn[16]}}, d_insn[16:0]};

   always_comb begin
      dec_aluop = 5'd0;
      dec_shamt = 5'd0;
      dec_wr    = 1'b0;
      use_imm   = 1'b0;
      case (op)
         5'b00000: begin
            dec_aluop = d_insn[6:2];
            dec_shamt = d_insn[11:7];
            dec_wr    = 1'b1;
         end
         5'b00101, 5'b01000: begin
            use_imm = 1'b1;
            dec_wr  = 1'b1;
         end
         5'b00111: use_imm = 1'b1;
         5'b00010, 5'b00110: dec_aluop = 5'b00001;
         default: ;
      endcase
   end

   always_comb begin
      nxt       = '0;
      nxt.valid = 1'b1;
      nxt.op_a  = src_val[0];
      nxt.op_b  = use_imm ? imm_ext : src_val[1];
      nxt.aluop = dec_aluop;
      nxt.shamt = dec_shamt;
      nxt.rd    = d_insn[26:22];
      nxt.wr_en = dec_wr && (d_insn[26:22] != 5'd0);
      nxt.pc    = d_pc;
      nxt.insn  = d_insn;
   end

`ifdef DX_BYPASS_EN
   logic unused_hit;
   assign unused_hit = |src_hit;
   assign hazard     = 1'b0;
`else
   // B only counts when the instruction actually reads it from the regfile
   assign hazard = d_valid && (src_hit[0] || (src_hit[1] && !use_imm));
`endif

   logic load_bubble;
   assign load_bubble = flush || (!hold && !d_valid);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cur          <= '0;
         bubble_count <= '0;
      end else begin
         if (flush)      cur <= '0;
         else if (!hold) cur <= d_valid ? nxt : '0;
         if (load_bubble && (bubble_count != {CNT_W{1'b1}}))
            bubble_count <= bubble_count + 1'b1;
      end
   end

   assign x_valid    = cur.valid;
   assign x_operandA = cur.op_a;
   assign x_operandB = cur.op_b;
   assign x_aluop    = cur.aluop;
   assign x_shamt    = cur.shamt;
   assign x_rd       = cur.rd;
   assign x_wr_en    = cur.wr_en;
   assign x_pc       = cur.pc;
   assign x_insn     = cur.insn;
endmodule

// File: tb/tb_dx_issue_latch.sv
// Scoreboarded random + directed bench for dx_issue_latch (bubble counter narrowed to 4 bits).
module tb_dx_issue_latch;
   localparam int CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clock = 1'b0, reset = 1'b0;
   logic d_valid, xm_wr_en, mw_wr_en, hold, flush;
   logic [31:0] d_insn, d_pc, d_a_data, d_b_data, xm_value, mw_value;
   logic [4:0] d_a_addr, d_b_addr, xm_rd, mw_rd;
   logic x_valid, x_wr_en, hazard;
   logic [31:0] x_operandA, x_operandB, x_pc, x_insn;
   logic [4:0] x_aluop, x_shamt, x_rd;
   logic [CW-1:0] bubble_count;

   always #5 clock = ~clock;

   dx_issue_latch #(.CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .d_valid(d_valid), .d_insn(d_insn), .d_pc(d_pc),
      .d_a_addr(d_a_addr), .d_b_addr(d_b_addr), .d_a_data(d_a_data), .d_b_data(d_b_data),
      .xm_wr_en(xm_wr_en), .xm_rd(xm_rd), .xm_value(xm_value),
      .mw_wr_en(mw_wr_en), .mw_rd(mw_rd), .mw_value(mw_value),
      .hold(hold), .flush(flush), .x_valid(x_valid), .x_operandA(x_operandA),
      .x_operandB(x_operandB), .x_aluop(x_aluop), .x_shamt(x_shamt), .x_rd(x_rd),
      .x_wr_en(x_wr_en), .x_pc(x_pc), .x_insn(x_insn), .hazard(hazard),
      .bubble_count(bubble_count)
   );

   typedef struct {
      logic valid; logic [31:0] a; logic [31:0] b; logic [4:0] aluop; logic [4:0] shamt;
      logic [4:0] rd; logic wr_en; logic [31:0] pc; logic [31:0] insn; int cnt; logic haz;
   } exp_t;

   exp_t q[$];
   exp_t m;
   int errors = 0, checks = 0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t bubble_e(input int cnt);
      exp_t e;
      e.valid = 0; e.a = 0; e.b = 0; e.aluop = 0; e.shamt = 0; e.rd = 0;
      e.wr_en = 0; e.pc = 0; e.insn = 0; e.cnt = cnt; e.haz = 0;
      return e;
   endfunction

   function automatic logic [31:0] src(input logic [4:0] a, input logic [31:0] rf);
      if (a == 0) return 32'd0;
`ifdef DX_BYPASS_EN
      if (xm_wr_en && xm_rd == a) return xm_value;
      if (mw_wr_en && mw_rd == a) return mw_value;
`endif
      return rf;
   endfunction

   function automatic bit is_imm(input int op);
      return op == 5 || op == 7 || op == 8;
   endfunction

   function automatic bit hit(input logic [4:0] a);
      return a != 0 && ((xm_wr_en && xm_rd == a) || (mw_wr_en && mw_rd == a));
   endfunction

   function automatic logic exp_haz();
`ifdef DX_BYPASS_EN
      return 1'b0;
`else
      int op = int'(d_insn[31:27]);
      return d_valid && (hit(d_a_addr) || (!is_imm(op) && hit(d_b_addr)));
`endif
   endfunction

   // records what the DUT shows until the coming edge, then advances the model over it
   task automatic step();
      exp_t e;
      int op, v;
      if (!reset) m = bubble_e(0);
      e = m; e.haz = exp_haz();
      q.push_back(e);
      if (reset) begin
         if (flush || (!hold && !d_valid)) begin
            m = bubble_e(m.cnt < CMAX ? m.cnt + 1 : CMAX);
         end else if (!hold) begin
            op = int'(d_insn[31:27]);
            m.valid = 1;
            m.a = src(d_a_addr, d_a_data);
            v = int'(d_insn[16:0]);
            if (v >= 65536) v = v - 131072;
            m.b = is_imm(op) ? 32'(v) : src(d_b_addr, d_b_data);
            m.aluop = (op == 0) ? d_insn[6:2] : (op == 2 || op == 6) ? 5'd1 : 5'd0;
            m.shamt = (op == 0) ? d_insn[11:7] : 5'd0;
            m.rd = d_insn[26:22];
            m.wr_en = (op == 0 || op == 5 || op == 8) && d_insn[26:22] != 0;
            m.pc = d_pc; m.insn = d_insn;
         end
      end
      @(posedge clock); #1;
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         cmp("x_valid", 32'(x_valid), 32'(e.valid));
         cmp("x_operandA", x_operandA, e.a);
         cmp("x_operandB", x_operandB, e.b);
         cmp("x_aluop", 32'(x_aluop), 32'(e.aluop));
         cmp("x_shamt", 32'(x_shamt), 32'(e.shamt));
         cmp("x_rd", 32'(x_rd), 32'(e.rd));
         cmp("x_wr_en", 32'(x_wr_en), 32'(e.wr_en));
         cmp("x_pc", x_pc, e.pc);
         cmp("x_insn", x_insn, e.insn);
         cmp("bubble_count", 32'(bubble_count), 32'(e.cnt));
         cmp("hazard", 32'(hazard), 32'(e.haz));
      end
   end

   function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, sh, al);
      return {op, rd, rs, rt, sh, al, 2'b00};
   endfunction

   task automatic idle();
      d_valid = 0; d_insn = 0; d_pc = 0; d_a_addr = 0; d_b_addr = 0; d_a_data = 0; d_b_data = 0;
      xm_wr_en = 0; xm_rd = 0; xm_value = 0; mw_wr_en = 0; mw_rd = 0; mw_value = 0;
      hold = 0; flush = 0;
   endtask

   task automatic rand_in(input bit ctl);
      int ops[7] = '{0, 5, 7, 8, 2, 6, 3};
      d_valid = ($urandom_range(0, 9) < 8);
      d_insn = $urandom;
      d_insn[31:27] = 5'(ops[$urandom_range(0, 6)]);
      d_pc = $urandom; d_a_data = $urandom; d_b_data = $urandom;
      d_a_addr = 5'($urandom_range(0, 7)); d_b_addr = 5'($urandom_range(0, 7));
      xm_wr_en = 1'($urandom); xm_rd = 5'($urandom_range(0, 7)); xm_value = $urandom;
      mw_wr_en = 1'($urandom); mw_rd = 5'($urandom_range(0, 7)); mw_value = $urandom;
      hold = ctl ? ($urandom_range(0, 9) < 2) : 1'($urandom);
      flush = ctl ? ($urandom_range(0, 9) < 1) : 1'($urandom);
   endtask

   logic [31:0] snap_a, snap_b, snap_insn;
   logic [CW-1:0] snap_cnt;

   initial begin
      m = bubble_e(0);
      reset = 0;
      rand_in(0);
      @(posedge clock); #1;
      // reset holds everything at zero regardless of inputs
      step(); rand_in(0); step();
      cmp("reset_valid", 32'(x_valid), 32'd0);

      // add r3,r1,r2
      idle(); reset = 1;
      d_valid = 1; d_insn = mk(0, 3, 1, 2, 0, 0); d_pc = 32'h100;
      d_a_addr = 1; d_b_addr = 2; d_a_data = 5; d_b_data = 7;
      step();
      cmp("add_A", x_operandA, 32'd5);
      cmp("add_B", x_operandB, 32'd7);
      cmp("add_aluop", 32'(x_aluop), 32'd0);
      cmp("add_valid", 32'(x_valid), 32'd1);

      // addi r4,r1,-3
      d_insn = {5'd5, 5'd4, 5'd1, 17'h1FFFD};
      step();
      cmp("addi_B", x_operandB, 32'hFFFF_FFFD);
      cmp("addi_wr_en", 32'(x_wr_en), 32'd1);
      cmp("addi_rd", 32'(x_rd), 32'd4);

      // forwarding priority
      d_insn = mk(0, 6, 2, 0, 0, 0); d_a_addr = 2; d_a_data = 32'h33;
      xm_wr_en = 1; xm_rd = 2; xm_value = 32'h11; mw_wr_en = 1; mw_rd = 2; mw_value = 32'h22;
      step();
`ifdef DX_BYPASS_EN
      cmp("fwd_xm", x_operandA, 32'h11);
`else
      cmp("fwd_xm", x_operandA, 32'h33);
`endif
      xm_wr_en = 0;
      step();
`ifdef DX_BYPASS_EN
      cmp("fwd_mw", x_operandA, 32'h22);
`else
      cmp("fwd_mw", x_operandA, 32'h33);
`endif
      d_a_addr = 0;
      step();
      cmp("fwd_r0", x_operandA, 32'd0);

      // hold freezes the latch, then flush overrides hold
      idle(); d_valid = 1; d_insn = mk(0, 9, 1, 2, 3, 4); d_a_addr = 1; d_a_data = 32'hA5;
      d_b_addr = 2; d_b_data = 32'h5A;
      step();
      snap_a = x_operandA; snap_b = x_operandB; snap_insn = x_insn; snap_cnt = bubble_count;
      for (int i = 0; i < 3; i++) begin
         rand_in(1); hold = 1; flush = 0;
         step();
         cmp("hold_A", x_operandA, snap_a);
         cmp("hold_B", x_operandB, snap_b);
         cmp("hold_insn", x_insn, snap_insn);
         cmp("hold_cnt", 32'(bubble_count), 32'(snap_cnt));
      end
      hold = 1; flush = 1;
      step();
      cmp("flush_valid", 32'(x_valid), 32'd0);
      cmp("flush_cnt", 32'(bubble_count), 32'(snap_cnt) + 32'd1);

      // RAW hazard flag
      idle(); d_valid = 1; d_insn = mk(0, 7, 5, 0, 0, 0); d_a_addr = 5; d_a_data = 32'h44;
      xm_wr_en = 1; xm_rd = 5; xm_value = 32'h99;
      #1;
`ifdef DX_BYPASS_EN
      cmp("hazard_set", 32'(hazard), 32'd0);
`else
      cmp("hazard_set", 32'(hazard), 32'd1);
`endif
      step();
`ifdef DX_BYPASS_EN
      cmp("hazard_opA", x_operandA, 32'h99);
`else
      cmp("hazard_opA", x_operandA, 32'h44);
`endif
      xm_rd = 0;
      #1;
      cmp("hazard_clr", 32'(hazard), 32'd0);

      // bubble counter saturation
      idle();
      for (int i = 0; i < (1 << CW) + 5; i++) step();
      cmp("cnt_sat", 32'(bubble_count), 32'(CMAX));

      // random traffic with occasional mid-stream reset
      reset = 0; step(); reset = 1;
      for (int i = 0; i < 400; i++) begin
         rand_in(1);
         reset = ($urandom_range(0, 49) != 0);
         step();
      end
      reset = 1; idle();
      step(); step();
      @(negedge clock); #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
